// File: rtl/axi_rd_arbiter_if.sv
// AXI4-lite read-channel bundle (AR + R) between the arbiter and the
// memory-side slave. The arbiter uses the master modport.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. A source holds valid and its payload stable until that edge,
// and valid never waits on ready. A sink may raise or lower ready at any time.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite read master between the IFU
// (port 0) and the LSU (port 1). Only one AXI transaction is in flight at a
// time. Requesters hold a level req until they see a one-cycle done pulse.
// Optional R-channel watchdog: define AXI_RD_TIMEOUT_EN.
module axi_rd_arbiter #(
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic               m0_req,
  input  logic [ADDR_W-1:0]  m0_addr,
  output logic               m0_done,
  input  logic               m1_req,
  input  logic [ADDR_W-1:0]  m1_addr,
  output logic               m1_done,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_err,
  axi_rd_arbiter_if.master   axi,
  output logic               grant,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              pick_valid;
  logic              pick;
  logic              capture;
  logic              timeout;
  logic [ADDR_W-1:0] araddr_q;

  // Round-robin choice: on a tie the port that was not served last wins.
  always_comb begin
    pick_valid = m0_req | m1_req;
    pick       = 1'b0;
    if (m0_req && m1_req) begin
      pick = ~last_grant;
    end else if (m1_req) begin
      pick = 1'b1;
    end
  end

`ifdef AXI_RD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt;

  // Watchdog: held at zero outside DATA, counts DATA cycles without rvalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state != S_DATA) begin
      cnt <= '0;
    end else if (!axi.rvalid) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (state == S_DATA) && !axi.rvalid &&
                   (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register; async reset abandons any transaction without a done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode. rvalid only matters in DATA, so a stray beat during
  // ADDR or IDLE is never captured.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_IDLE: if (pick_valid) state_nxt = S_ADDR;
      S_ADDR: if (axi.arready) state_nxt = S_DATA;
      S_DATA: begin
        if (axi.rvalid) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else if (timeout) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant/address latch at grant time, read result capture, fairness update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      araddr_q   <= '0;
      rd_data    <= '0;
      rd_err     <= 1'b0;
    end else begin
      if (state == S_IDLE && pick_valid) begin
        grant    <= pick;
        araddr_q <= pick ? m1_addr : m0_addr;
      end
      if (capture) begin
        rd_data <= axi.rdata;
        rd_err  <= axi.rresp[1];
      end else if (timeout) begin
        rd_data <= '0;
        rd_err  <= 1'b1;
      end
      if (state == S_RESP) begin
        last_grant <= grant;
      end
    end
  end

  // All handshake outputs decode straight from registered state.
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = (state == S_ADDR);
  assign axi.rready  = (state == S_DATA);
  assign m0_done     = (state == S_RESP) && !grant;
  assign m1_done     = (state == S_RESP) &&  grant;
  assign busy        = (state != S_IDLE);
  assign dbg_state   = state;

  // rresp[0] only distinguishes OKAY from EXOKAY, which reads treat alike.
  logic unused_ok;
  assign unused_ok = ^{axi.rresp[0], (TIMEOUT_CYC == 0)};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a table of single-transaction vectors
// with hand-computed results, then hand-written multi-cycle sequences.
module tb_axi_rd_arbiter;
  localparam int ADDR_W      = 64;
  localparam int DATA_W      = 64;
  localparam int TIMEOUT_CYC = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              m0_req = 1'b0;
  logic              m1_req = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic              m0_done, m1_done, rd_err, grant, busy;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        dbg_state;

  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_rd_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_done(m0_done),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_done(m1_done),
    .rd_data(rd_data), .rd_err(rd_err),
    .axi(axi),
    .grant(grant), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, 64'(axi.arvalid), 64'd0);
    chk({tag, "_rready"},  64'(axi.rready),  64'd0);
    chk({tag, "_araddr"},  axi.araddr,       64'd0);
    chk({tag, "_m0_done"}, 64'(m0_done),     64'd0);
    chk({tag, "_m1_done"}, 64'(m1_done),     64'd0);
    chk({tag, "_busy"},    64'(busy),        64'd0);
    chk({tag, "_grant"},   64'(grant),       64'd0);
    chk({tag, "_rd_data"}, rd_data,          64'd0);
    chk({tag, "_rd_err"},  64'(rd_err),      64'd0);
    chk({tag, "_state"},   64'(dbg_state),   64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        req0;
    logic        req1;
    logic [63:0] addr0;
    logic [63:0] addr1;
    int          ar_dly;
    int          r_dly;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        exp_grant;
    logic [63:0] exp_araddr;
    logic [63:0] exp_rd_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  // Driver + slave model for one transaction. Requests are raised in an IDLE
  // cycle; the owner drops its req in the cycle where its done is seen.
  task automatic run_vec(input string tag, input vec_t v);
    int  ar_wait;
    int  r_wait;
    bit  got;
    m0_req  = v.req0;
    m1_req  = v.req1;
    m0_addr = v.addr0;
    m1_addr = v.addr1;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    exp_q.push_back(v.exp_rd_data);
    ar_wait = 0;
    r_wait  = 0;
    got     = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (axi.arvalid) begin
        chk({tag, "_araddr"}, axi.araddr, v.exp_araddr);
        chk({tag, "_rready_in_addr"}, 64'(axi.rready), 64'd0);
        chk({tag, "_grant_in_addr"}, 64'(grant), 64'(v.exp_grant));
        axi.rvalid = 1'b0;
        if (ar_wait < v.ar_dly) begin
          axi.arready = 1'b0;
          ar_wait++;
        end else begin
          axi.arready = 1'b1;
        end
      end else if (axi.rready) begin
        axi.arready = 1'b0;
        if (r_wait < v.r_dly) begin
          axi.rvalid = 1'b0;
          axi.rdata  = '0;
          r_wait++;
        end else begin
          axi.rvalid = 1'b1;
          axi.rdata  = v.rdata;
          axi.rresp  = v.rresp;
        end
      end else if (m0_done || m1_done) begin
        got = 1'b1;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        chk({tag, "_latency"}, 64'(k), 64'(v.exp_lat));
        chk({tag, "_m0_done"}, 64'(m0_done), 64'(!v.exp_grant));
        chk({tag, "_m1_done"}, 64'(m1_done), 64'(v.exp_grant));
        chk({tag, "_grant"},   64'(grant),   64'(v.exp_grant));
        chk({tag, "_rd_data"}, rd_data,      exp_q.pop_front());
        chk({tag, "_rd_err"},  64'(rd_err),  64'(v.exp_err));
        if (v.exp_grant) m1_req = 1'b0;
        else             m0_req = 1'b0;
      end else begin
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_wait: actual no done in 40 cycles required done", tag);
      void'(exp_q.pop_front());
    end
    // IDLE cycle after RESP: one-cycle done, results held.
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_done"}, 64'({m0_done, m1_done}), 64'd0);
    chk({tag, "_hold_data"}, rd_data, v.exp_rd_data);
  endtask

  int data_cyc;
  bit got_done;

  initial begin
    // pattern: req0 req1 addr0 addr1 ar_dly r_dly rdata rresp | grant araddr rd_data err latency
    vecs[0]  = '{1'b1, 1'b1, 64'h1000, 64'h2000, 0, 0, 64'h11, 2'b00, 1'b0, 64'h1000, 64'h11, 1'b0, 3};
    vecs[1]  = '{1'b0, 1'b1, 64'h1000, 64'h2000, 0, 0, 64'h22, 2'b00, 1'b1, 64'h2000, 64'h22, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 64'h8000_0000, 64'h0, 0, 0, 64'h13, 2'b00, 1'b0, 64'h8000_0000, 64'h13, 1'b0, 3};
    vecs[3]  = '{1'b1, 1'b1, 64'h3000, 64'h4000, 0, 0, 64'h31, 2'b00, 1'b1, 64'h4000, 64'h31, 1'b0, 3};
    vecs[4]  = '{1'b1, 1'b1, 64'h3000, 64'h4000, 0, 0, 64'h32, 2'b00, 1'b0, 64'h3000, 64'h32, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b1, 64'h3000, 64'h4000, 0, 0, 64'h33, 2'b00, 1'b1, 64'h4000, 64'h33, 1'b0, 3};
    vecs[6]  = '{1'b1, 1'b1, 64'h3000, 64'h4000, 0, 0, 64'h34, 2'b00, 1'b0, 64'h3000, 64'h34, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b0, 64'h5000, 64'h0, 5, 0, 64'h55, 2'b00, 1'b0, 64'h5000, 64'h55, 1'b0, 8};
    vecs[8]  = '{1'b0, 1'b1, 64'h0, 64'h6000, 0, 0, 64'hDEAD, 2'b10, 1'b1, 64'h6000, 64'hDEAD, 1'b1, 3};
    vecs[9]  = '{1'b0, 1'b1, 64'h0, 64'h6008, 0, 2, 64'hBEEF, 2'b11, 1'b1, 64'h6008, 64'hBEEF, 1'b1, 5};
    vecs[10] = '{1'b0, 1'b1, 64'h0, 64'h6010, 1, 0, 64'hCAFE, 2'b01, 1'b1, 64'h6010, 64'hCAFE, 1'b0, 4};
    vecs[11] = '{1'b1, 1'b0, 64'h7000, 64'h0, 2, 3, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b0, 64'h7000,
                 64'h0123_4567_89AB_CDEF, 1'b0, 8};

    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;

    // Reset
    #2 rst = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Address change and req drop after grant; rvalid during ADDR ignored.
    m0_req = 1'b0;
    m1_req = 1'b1;
    m1_addr = 64'hA000;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    @(negedge clk);
    chk("seqa_arvalid", 64'(axi.arvalid), 64'd1);
    chk("seqa_araddr",  axi.araddr, 64'hA000);
    chk("seqa_grant",   64'(grant), 64'd1);
    m1_addr = 64'hB000;
    m1_req  = 1'b0;
    axi.rvalid = 1'b1;
    axi.rdata  = 64'hBAD;
    axi.rresp  = 2'b10;
    @(negedge clk);
    chk("seqa_arvalid_held", 64'(axi.arvalid), 64'd1);
    chk("seqa_araddr_held",  axi.araddr, 64'hA000);
    chk("seqa_rready_low",   64'(axi.rready), 64'd0);
    axi.arready = 1'b1;
    @(negedge clk);
    chk("seqa_rready", 64'(axi.rready), 64'd1);
    chk("seqa_arvalid_low", 64'(axi.arvalid), 64'd0);
    axi.arready = 1'b0;
    axi.rdata   = 64'h55;
    axi.rresp   = 2'b00;
    @(negedge clk);
    chk("seqa_m1_done", 64'(m1_done), 64'd1);
    chk("seqa_rd_data", rd_data, 64'h55);
    chk("seqa_rd_err",  64'(rd_err), 64'd0);
    axi.rvalid = 1'b0;
    @(negedge clk);
    chk("seqa_idle_busy", 64'(busy), 64'd0);
    chk("seqa_no_done",   64'(m1_done), 64'd0);
    chk("seqa_hold_data", rd_data, 64'h55);

    // Reset in the middle of DATA, then tie goes to m0 again.
    m1_req  = 1'b1;
    m1_addr = 64'h9000;
    axi.arready = 1'b1;
    axi.rvalid  = 1'b0;
    @(negedge clk);
    chk("seqb_arvalid", 64'(axi.arvalid), 64'd1);
    @(negedge clk);
    chk("seqb_rready", 64'(axi.rready), 64'd1);
    #1 rst = 1'b0;
    #1 chk_all_zero("seqb_rst");
    m1_req = 1'b0;
    axi.arready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("seqb_after_busy", 64'(busy), 64'd0);
    chk("seqb_after_done", 64'({m0_done, m1_done}), 64'd0);
    run_vec("seqb_tie", '{1'b1, 1'b1, 64'hC000, 64'hD000, 0, 0, 64'h77, 2'b00,
                          1'b0, 64'hC000, 64'h77, 1'b0, 3});

`ifdef AXI_RD_TIMEOUT_EN
    // Watchdog: no rvalid ever arrives.
    m0_req  = 1'b1;
    m0_addr = 64'hE000;
    axi.arready = 1'b1;
    axi.rvalid  = 1'b0;
    data_cyc = 0;
    got_done = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      @(negedge clk);
      if (axi.rready) data_cyc++;
      if (m0_done) begin
        got_done = 1'b1;
        m0_req = 1'b0;
        chk("to_data_cycles", 64'(data_cyc), 64'(TIMEOUT_CYC));
        chk("to_rd_err",  64'(rd_err), 64'd1);
        chk("to_rd_data", rd_data, 64'd0);
        chk("to_rready",  64'(axi.rready), 64'd0);
      end
    end
    if (!got_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL to_done_wait: actual no done in 40 cycles required done");
    end
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rdata   = 64'hFFFF;
    @(negedge clk);
    @(negedge clk);
    chk("to_late_rready", 64'(axi.rready), 64'd0);
    chk("to_late_busy",   64'(busy), 64'd0);
    chk("to_late_data",   rd_data, 64'd0);
    axi.rvalid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
